// File: rtl/cmos_pkg.sv
// Shared types and constants for the CMOS camera capture block.
// Holds the frame FSM states, RGB565 field widths and geometry defaults.
package cmos_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_VSYNC  = 2'd1,
    ST_SKIP   = 2'd2,
    ST_ACTIVE = 2'd3
  } cap_state_t;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int PIX_W = R_W + G_W + B_W;

  localparam int HOR_NUM_DEF = 512;
  localparam int VER_NUM_DEF = 8;

endpackage

// File: rtl/cmos_byte_pack.sv
// Packs the high/low byte stream of one line into RGB565 pixels and
// checks the line length (short, long or odd byte count) on href fall.
module cmos_byte_pack
  import cmos_pkg::*;
#(
  parameter int HOR_NUM = HOR_NUM_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_abort,
  input  logic             i_href,
  input  logic             i_href_fall,
  input  logic             i_first_line,
  input  logic [7:0]       i_data,
  output logic [PIX_W-1:0] o_pix_data,
  output logic             o_pix_valid,
  output logic             o_pix_sof,
  output logic             o_pix_eol,
  output logic             o_len_err
);

  localparam int CW = $clog2(HOR_NUM + 1);
  localparam logic [CW-1:0] HN = CW'(HOR_NUM);

  logic          r_phase;
  logic          r_long;
  logic [7:0]    r_hi;
  logic [CW-1:0] r_pix_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase     <= 1'b0;
      r_long      <= 1'b0;
      r_hi        <= '0;
      r_pix_cnt   <= '0;
      o_pix_data  <= '0;
      o_pix_valid <= 1'b0;
      o_pix_sof   <= 1'b0;
      o_pix_eol   <= 1'b0;
      o_len_err   <= 1'b0;
    end else begin
      o_pix_valid <= 1'b0;
      o_pix_sof   <= 1'b0;
      o_pix_eol   <= 1'b0;
      o_len_err   <= 1'b0;
      // A vsync rise abandons the line silently; no length verdict.
      if (i_abort) begin
        r_phase   <= 1'b0;
        r_long    <= 1'b0;
        r_pix_cnt <= '0;
      end else if (i_href_fall) begin
        o_len_err <= i_en && ((r_pix_cnt != HN) || r_long || r_phase);
        r_phase   <= 1'b0;
        r_long    <= 1'b0;
        r_pix_cnt <= '0;
      end else if (i_en && i_href) begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_hi <= i_data;
        end else if (r_pix_cnt < HN) begin
          o_pix_data  <= {r_hi, i_data};
          o_pix_valid <= 1'b1;
          o_pix_sof   <= i_first_line && (r_pix_cnt == '0);
          o_pix_eol   <= (r_pix_cnt == HN - CW'(1));
          r_pix_cnt   <= r_pix_cnt + CW'(1);
        end else begin
          r_long <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cmos_capture.sv
// CMOS camera frame capture: syncs vsync/href/data, runs the frame FSM and
// feeds the byte packer. Optional counters under CMOS_CAPTURE_STAT_EN.
module cmos_capture
  import cmos_pkg::*;
#(
  parameter int HOR_NUM     = HOR_NUM_DEF,
  parameter int VER_NUM     = VER_NUM_DEF,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic        cmos_vsyn,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  input  logic        cap_en,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done,
  output logic        len_err
`ifdef CMOS_CAPTURE_STAT_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int SW = $clog2(SKIP_FRAMES + 2);
  localparam int LW = $clog2(VER_NUM + 1);
  localparam logic [SW-1:0] SK = SW'(SKIP_FRAMES);
  localparam logic [LW-1:0] VN = LW'(VER_NUM);

  logic          r_vsyn, r_vsyn_d, r_href, r_href_d;
  logic [7:0]    r_data;
  logic [SW-1:0] r_skip_cnt;
  logic [LW-1:0] r_line_cnt;
  cap_state_t    r_state, w_nxt;
  logic          w_skip_inc, w_vs_rise, w_vs_fall, w_href_fall, w_en;

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsyn   <= 1'b0;
      r_vsyn_d <= 1'b0;
      r_href   <= 1'b0;
      r_href_d <= 1'b0;
      r_data   <= '0;
    end else begin
      r_vsyn   <= cmos_vsyn;
      r_vsyn_d <= r_vsyn;
      r_href   <= cmos_href;
      r_href_d <= r_href;
      r_data   <= cmos_data;
    end
  end

  assign w_vs_rise   = r_vsyn & ~r_vsyn_d;
  assign w_vs_fall   = ~r_vsyn & r_vsyn_d;
  assign w_href_fall = ~r_href & r_href_d;
  // Lines past VER_NUM and the vsync-rise cycle itself are not packed.
  assign w_en = (r_state == ST_ACTIVE) && (r_line_cnt < VN) && !w_vs_rise;

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT;
      r_skip_cnt <= '0;
      r_line_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_skip_inc) r_skip_cnt <= r_skip_cnt + SW'(1);
      if (w_vs_rise)
        r_line_cnt <= '0;
      else if (r_state == ST_ACTIVE && w_href_fall && r_line_cnt < VN)
        r_line_cnt <= r_line_cnt + LW'(1);
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_skip_inc = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      ST_WAIT:   if (w_vs_rise) w_nxt = ST_VSYNC;
      ST_VSYNC:  if (w_vs_fall) w_nxt = (r_skip_cnt < SK || !cap_en) ? ST_SKIP : ST_ACTIVE;
      ST_SKIP:   if (w_vs_rise) begin
                   w_nxt      = ST_VSYNC;
                   w_skip_inc = (r_skip_cnt < SK);
                 end
      ST_ACTIVE: if (w_vs_rise) begin
                   w_nxt      = ST_VSYNC;
                   frame_done = 1'b1;
                 end
      default:   w_nxt = ST_WAIT;
    endcase
  end

  cmos_byte_pack #(.HOR_NUM(HOR_NUM)) u_pack (
    .i_clk        (cmos_pclk),
    .i_rst_n      (rst_n),
    .i_en         (w_en),
    .i_abort      (w_vs_rise),
    .i_href       (r_href),
    .i_href_fall  (w_href_fall),
    .i_first_line (r_line_cnt == '0),
    .i_data       (r_data),
    .o_pix_data   (pix_data),
    .o_pix_valid  (pix_valid),
    .o_pix_sof    (pix_sof),
    .o_pix_eol    (pix_eol),
    .o_len_err    (len_err)
  );

`ifdef CMOS_CAPTURE_STAT_EN
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (len_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
